// File: rtl/snl_game_engine.sv
`default_nettype none
// ============================================================================
// Module      : snl_game_engine
// Description : N-player Snakes-and-Ladders turn engine with LFSR die and
//               run-time programmable snake/ladder jump table.
// Revision    : 1.0 - initial release
// ============================================================================
module snl_game_engine #(
    parameter int          NUM_PLAYERS = 4,
    parameter int          BOARD_SIZE  = 100,
    parameter int          POS_W       = 7,
    parameter int          NUM_JUMPS   = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         PW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int         JW          = (NUM_JUMPS > 1) ? $clog2(NUM_JUMPS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         roll_req,
    input  logic                         dice_force_en,
    input  logic [2:0]                   dice_force_val,
    input  logic                         jump_wr_en,
    input  logic [JW-1:0]                jump_wr_idx,
    input  logic [POS_W-1:0]             jump_wr_from,
    input  logic [POS_W-1:0]             jump_wr_to,
    output logic [NUM_PLAYERS*POS_W-1:0] positions,
    output logic [PW-1:0]                cur_player,
    output logic [2:0]                   last_roll,
    output logic                         busy,
    output logic                         move_valid,
    output logic                         game_over,
    output logic [PW-1:0]                winner
);

    localparam logic [POS_W-1:0] c_board       = POS_W'(BOARD_SIZE);
    localparam logic [POS_W:0]   c_board_ext   = (POS_W+1)'(BOARD_SIZE);
    localparam logic [PW-1:0]    c_last_player = PW'(NUM_PLAYERS - 1);
    localparam logic [JW:0]      c_num_jumps   = (JW+1)'(NUM_JUMPS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ROLL   = 3'd1,
        ST_STEP   = 3'd2,
        ST_JUMP   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    logic [15:0]      r_lfsr;
    logic [POS_W-1:0] r_pos [NUM_PLAYERS];
    logic [PW-1:0]    r_cur;
    logic [2:0]       r_last_roll;
    logic [1:0]       r_six_cnt;
    logic [POS_W-1:0] r_tent;
    logic             r_busy;
    logic             r_move_valid;
    logic             r_game_over;
    logic [PW-1:0]    r_winner;

    logic             r_jv    [NUM_JUMPS];
    logic [POS_W-1:0] r_jfrom [NUM_JUMPS];
    logic [POS_W-1:0] r_jto   [NUM_JUMPS];

    logic             w_lfsr_fb;
    logic [2:0]       w_die;
    logic [2:0]       w_force;
    logic [2:0]       w_roll_src;
    logic [POS_W-1:0] w_cur_pos;
    logic [POS_W:0]   w_sum;
    logic             w_no_move;
    logic [POS_W-1:0] w_jump_dest;
    logic             w_wr_ok;
    logic [PW-1:0]    w_next_player;

    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_die      = 3'(r_lfsr % 16'd6) + 3'd1;
    assign w_force    = (dice_force_val >= 3'd1 && dice_force_val <= 3'd6) ? dice_force_val : 3'd1;
    assign w_roll_src = dice_force_en ? w_force : w_die;

    assign w_cur_pos     = r_pos[r_cur];
    assign w_sum         = {1'b0, w_cur_pos} + (POS_W+1)'(r_last_roll);
    // Overshoot and a third consecutive six both leave the player in place
    assign w_no_move     = (w_sum > c_board_ext) || (r_last_roll == 3'd6 && r_six_cnt == 2'd3);
    assign w_next_player = (r_cur == c_last_player) ? '0 : r_cur + 1'b1;

    assign w_wr_ok = jump_wr_en && !r_busy && ({1'b0, jump_wr_idx} < c_num_jumps)
                     && (jump_wr_to != '0) && (jump_wr_to <= c_board);

    // Scan from the top so the lowest matching index ends up winning
    always_comb begin
        w_jump_dest = r_tent;
        for (int j = NUM_JUMPS - 1; j >= 0; j--) begin
            if (r_jv[j] && r_jfrom[j] == r_tent) begin
                w_jump_dest = r_jto[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < NUM_JUMPS; j++) begin
                r_jv[j]    <= 1'b0;
                r_jfrom[j] <= '0;
                r_jto[j]   <= '0;
            end
        end else if (w_wr_ok) begin
            r_jv[jump_wr_idx]    <= (jump_wr_from != '0);
            r_jfrom[jump_wr_idx] <= jump_wr_from;
            r_jto[jump_wr_idx]   <= jump_wr_to;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_lfsr       <= LFSR_SEED;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_pos[p] <= '0;
            end
            r_cur        <= '0;
            r_last_roll  <= 3'd0;
            r_six_cnt    <= 2'd0;
            r_tent       <= '0;
            r_busy       <= 1'b0;
            r_move_valid <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= '0;
        end else begin
            r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};
            r_move_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (roll_req) begin
                        r_busy  <= 1'b1;
                        r_state <= ST_ROLL;
                    end
                end
                ST_ROLL: begin
                    r_last_roll <= w_roll_src;
                    if (w_roll_src == 3'd6) begin
                        r_six_cnt <= r_six_cnt + 2'd1;
                    end
                    r_state <= ST_STEP;
                end
                ST_STEP: begin
                    r_tent  <= w_no_move ? w_cur_pos : w_sum[POS_W-1:0];
                    r_state <= ST_JUMP;
                end
                ST_JUMP: begin
                    r_tent  <= w_jump_dest;
                    r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_pos[r_cur] <= r_tent;
                    r_move_valid <= 1'b1;
                    r_busy       <= 1'b0;
                    if (r_tent == c_board) begin
                        r_game_over <= 1'b1;
                        r_winner    <= r_cur;
                        r_state     <= ST_DONE;
                    end else begin
                        if (!(r_last_roll == 3'd6 && r_six_cnt < 2'd3)) begin
                            r_cur     <= w_next_player;
                            r_six_cnt <= 2'd0;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pos
        assign positions[p*POS_W +: POS_W] = r_pos[p];
    end

    assign cur_player = r_cur;
    assign last_roll  = r_last_roll;
    assign busy       = r_busy;
    assign move_valid = r_move_valid;
    assign game_over  = r_game_over;
    assign winner     = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_snl_game_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_snl_game_engine
// Description : Self-checking bench for snl_game_engine against a rule-level
//               game model (4 players, 100 squares, 8 jump entries).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snl_game_engine;

    localparam int c_np    = 4;
    localparam int c_board = 100;
    localparam int c_nj    = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        roll_req = 1'b0;
    logic        dice_force_en = 1'b0;
    logic [2:0]  dice_force_val = 3'd0;
    logic        jump_wr_en = 1'b0;
    logic [2:0]  jump_wr_idx = 3'd0;
    logic [6:0]  jump_wr_from = 7'd0;
    logic [6:0]  jump_wr_to = 7'd0;
    logic [27:0] positions;
    logic [1:0]  cur_player;
    logic [2:0]  last_roll;
    logic        busy;
    logic        move_valid;
    logic        game_over;
    logic [1:0]  winner;

    snl_game_engine dut (
        .clk            (clk),
        .reset          (reset),
        .roll_req       (roll_req),
        .dice_force_en  (dice_force_en),
        .dice_force_val (dice_force_val),
        .jump_wr_en     (jump_wr_en),
        .jump_wr_idx    (jump_wr_idx),
        .jump_wr_from   (jump_wr_from),
        .jump_wr_to     (jump_wr_to),
        .positions      (positions),
        .cur_player     (cur_player),
        .last_roll      (last_roll),
        .busy           (busy),
        .move_valid     (move_valid),
        .game_over      (game_over),
        .winner         (winner)
    );

    always #5 clk = ~clk;

    // Reference die: x^16+x^14+x^13+x^11+1, one step per clock out of reset
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int n_assert = 0;
    int n_fail   = 0;

    int m_pos [c_np];
    int m_cur, m_six, m_win;
    bit m_over;
    int m_from [c_nj];
    int m_to   [c_nj];
    bit m_val  [c_nj];
    int faces  [7];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int jump_of(input int sq);
        for (int j = 0; j < c_nj; j++) begin
            if (m_val[j] && m_from[j] == sq) return m_to[j];
        end
        return sq;
    endfunction

    function automatic logic [27:0] exp_positions();
        logic [27:0] v;
        for (int p = 0; p < c_np; p++) v[p*7 +: 7] = 7'(m_pos[p]);
        return v;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < c_np; p++) m_pos[p] = 0;
        for (int j = 0; j < c_nj; j++) begin
            m_val[j] = 0; m_from[j] = 0; m_to[j] = 0;
        end
        m_cur = 0; m_six = 0; m_win = 0; m_over = 0;
    endtask

    task automatic model_turn(input int roll);
        int  t;
        bit  forfeit;
        if (roll == 6) m_six++;
        forfeit = (roll == 6) && (m_six == 3);
        t = m_pos[m_cur] + roll;
        if (t > c_board || forfeit) t = m_pos[m_cur];
        t = jump_of(t);
        m_pos[m_cur] = t;
        if (t == c_board) begin
            m_over = 1;
            m_win  = m_cur;
        end else if (!(roll == 6 && m_six < 3)) begin
            m_cur = (m_cur + 1) % c_np;
            m_six = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_positions"}, 32'(positions), 32'(exp_positions()));
        chk({tag, "_cur_player"}, 32'(cur_player), 32'(m_cur));
        chk({tag, "_game_over"}, 32'(game_over), 32'(m_over));
        chk({tag, "_winner"}, 32'(winner), 32'(m_win));
    endtask

    task automatic do_reset();
        reset = 1'b1; roll_req = 1'b0; jump_wr_en = 1'b0; dice_force_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        check_outputs("reset");
        chk("reset_last_roll", 32'(last_roll), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_move_valid", 32'(move_valid), 0);
    endtask

    // Table write issued while idle; accepted entries go into the model
    task automatic jwrite(input int idx, input int from, input int to);
        jump_wr_en = 1'b1; jump_wr_idx = 3'(idx); jump_wr_from = 7'(from); jump_wr_to = 7'(to);
        @(posedge clk);
        #1 jump_wr_en = 1'b0;
        if (to != 0 && to <= c_board && idx < c_nj) begin
            m_val[idx]  = (from != 0);
            m_from[idx] = from;
            m_to[idx]   = to;
        end
    endtask

    // One turn starting from IDLE; optionally attempts a table write while busy
    task automatic do_turn(input bit fe, input int fv, input bit bw, input int bidx, input int bfrom, input int bto);
        int exp_roll;
        int n;
        bit seen;
        dice_force_en = fe; dice_force_val = fv[2:0]; roll_req = 1'b1;
        @(posedge clk);
        #1 roll_req = 1'b0;
        chk("busy_in_turn", 32'(busy), 1);
        if (fe) exp_roll = (fv >= 1 && fv <= 6) ? fv : 1;
        else    exp_roll = int'(m_lfsr % 16'd6) + 1;
        if (bw) begin
            jump_wr_en = 1'b1; jump_wr_idx = 3'(bidx); jump_wr_from = 7'(bfrom); jump_wr_to = 7'(bto);
        end
        n = 0; seen = 0;
        while (!seen && n < 10) begin
            @(posedge clk);
            #1 jump_wr_en = 1'b0;
            n++;
            if (move_valid) seen = 1;
        end
        chk("turn_latency", 32'(n), 4);
        chk("last_roll", 32'(last_roll), 32'(exp_roll));
        model_turn(exp_roll);
        check_outputs("turn");
    endtask

    initial begin
        int mv_cnt, busy_cnt, in_range;
        logic [27:0] held_pos;

        // Reset values, then three back-to-back forced turns on an empty table
        do_reset();
        do_turn(1, 3, 0, 0, 0, 0);
        do_turn(1, 4, 0, 0, 0, 0);
        do_turn(1, 5, 0, 0, 0, 0);
        chk("b2b_positions", 32'(positions), 32'({7'd0, 7'd5, 7'd4, 7'd3}));

        // Jump table: ladders, snakes, ignored writes, priority, clearing
        do_reset();
        jwrite(0, 3, 22);
        jwrite(1, 17, 4);
        jwrite(2, 5, 0);
        jwrite(3, 6, 101);
        jwrite(4, 9, 70);
        jwrite(5, 9, 80);
        jwrite(6, 30, 90);
        jwrite(6, 0, 1);
        do_turn(1, 3, 0, 0, 0, 0);
        chk("ladder_3_22", 32'(positions[6:0]), 22);
        do_turn(1, 6, 0, 0, 0, 0);
        do_turn(1, 6, 0, 0, 0, 0);
        do_turn(1, 5, 0, 0, 0, 0);
        chk("snake_17_4", 32'(positions[13:7]), 4);
        do_turn(1, 5, 1, 7, 11, 99);
        do_turn(1, 6, 0, 0, 0, 0);
        do_turn(1, 6, 0, 0, 0, 0);
        do_turn(1, 6, 0, 0, 0, 0);
        chk("third_six_forfeit", 32'(positions[27:21]), 12);
        do_turn(1, 6, 0, 0, 0, 0);
        do_turn(1, 2, 0, 0, 0, 0);
        do_turn(1, 5, 0, 0, 0, 0);
        do_turn(1, 6, 0, 0, 0, 0);
        do_turn(1, 0, 0, 0, 0, 0);
        do_turn(1, 7, 0, 0, 0, 0);

        // Reset landing one cycle after E2 aborts the turn
        dice_force_en = 1'b1; dice_force_val = 3'd3; roll_req = 1'b1;
        @(posedge clk);
        #1 roll_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs("abort");
        chk("abort_last_roll", 32'(last_roll), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_move_valid", 32'(move_valid), 0);
        reset = 1'b0;
        mv_cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (move_valid) mv_cnt++;
        end
        chk("abort_no_pulse", 32'(mv_cnt), 0);

        // Exact landing: overshoot stays put, then ladder-free win by player 1
        jwrite(0, 2, 98);
        do_turn(1, 1, 0, 0, 0, 0);
        do_turn(1, 2, 0, 0, 0, 0);
        do_turn(1, 3, 0, 0, 0, 0);
        do_turn(1, 3, 0, 0, 0, 0);
        do_turn(1, 3, 0, 0, 0, 0);
        do_turn(1, 5, 0, 0, 0, 0);
        chk("overshoot_stays", 32'(positions[13:7]), 98);
        do_turn(1, 1, 0, 0, 0, 0);
        do_turn(1, 1, 0, 0, 0, 0);
        do_turn(1, 1, 0, 0, 0, 0);
        do_turn(1, 2, 0, 0, 0, 0);
        chk("win_flag", 32'(game_over), 1);
        chk("win_player", 32'(winner), 1);
        held_pos = positions;
        roll_req = 1'b1;
        mv_cnt = 0; busy_cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (move_valid) mv_cnt++;
            if (busy) busy_cnt++;
        end
        roll_req = 1'b0;
        chk("done_no_pulse", 32'(mv_cnt), 0);
        chk("done_no_busy", 32'(busy_cnt), 0);
        chk("done_positions_held", 32'(positions), 32'(held_pos));
        check_outputs("done");

        // Free-running die over 1000 turns; entry 7 snakes square 100 so no one wins
        do_reset();
        for (int j = 0; j < 7; j++) jwrite(j, $urandom_range(100, 1), $urandom_range(99, 1));
        jwrite(7, 100, 1);
        for (int f = 0; f < 7; f++) faces[f] = 0;
        in_range = 0;
        for (int k = 0; k < 1000; k++) begin
            int g;
            g = $urandom_range(3, 0);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            do_turn(0, 0, 0, 0, 0, 0);
            if (last_roll >= 3'd1 && last_roll <= 3'd6) begin
                in_range++;
                faces[last_roll]++;
            end
        end
        chk("die_in_range", 32'(in_range), 1000);
        for (int f = 1; f <= 6; f++) chk($sformatf("face_%0d_over_100", f), 32'(faces[f] > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snl_game_engine.md
# snl_game_engine

Parametrised multi-player Snakes-and-Ladders turn engine: one on-chip LFSR die, N players sharing it in round-robin, a run-time programmable snake/ladder jump table, exact-landing win rule and a six-grants-extra-turn rule. It replaces the fixed two-player controller. It sits between the board-display/UI logic (which issues `roll_req` and reads positions) and the configuration host (which loads the jump table).

## Interface
- `NUM_PLAYERS`, default 4: number of players, 2..8.
- `BOARD_SIZE`, default 100: last square. Squares are 1..BOARD_SIZE; 0 means off-board (start).
- `POS_W`, default 7: position width. Must satisfy 2^POS_W > BOARD_SIZE.
- `NUM_JUMPS`, default 8: jump-table entries.
- `LFSR_SEED`, default 16'hACE1: die LFSR reset value, must be nonzero.
- `PW` (local) = max(1, clog2(NUM_PLAYERS)). `JW` (local) = max(1, clog2(NUM_JUMPS)).
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in, 1: clock.
- `reset` in, 1: synchronous, active-high; initialises every register.
- `roll_req` in, 1: take-turn request. Sampled only in IDLE.
- `dice_force_en` in, 1: when high, the ROLL state uses `dice_force_val` instead of the LFSR.
- `dice_force_val` in, 3: forced die value. Values 1..6 only; any other value is treated as 1.
- `jump_wr_en` in, 1: jump-table write strobe.
- `jump_wr_idx` in, JW: table entry to write.
- `jump_wr_from` in, POS_W: head square of the snake or ladder. 0 invalidates the entry.
- `jump_wr_to` in, POS_W: destination square.
- `positions` out, NUM_PLAYERS*POS_W: player p occupies bits [p*POS_W +: POS_W].
- `cur_player` out, PW: player whose turn it is.
- `last_roll` out, 3: die value of the most recent turn.
- `busy` out, 1: high while a turn is in progress.
- `move_valid` out, 1: one-cycle pulse when a turn commits.
- `game_over` out, 1: sticky until reset.
- `winner` out, PW: valid while `game_over` is high.

## Operation
- Reset values:
  - `positions` all 0; `cur_player` 0; `last_roll` 0.
  - `busy`, `move_valid`, `game_over`, `winner` all 0.
  - All jump entries invalid; LFSR = LFSR_SEED; six counter 0; state IDLE.
- Die:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11. It advances every cycle out of reset, in every state.
  - Roll value = (lfsr mod 6) + 1, captured in ROLL.
- Jump table:
  - A write takes effect at the next edge, and only when `busy` is 0.
  - A write is ignored when `jump_wr_idx` >= NUM_JUMPS, when `jump_wr_to` is 0, or when `jump_wr_to` > BOARD_SIZE.
  - Writing `from` = 0 clears the entry.
  - Lookup: the lowest-index valid entry whose `from` equals the tentative square wins.
  - Only one jump is applied per move; landing on another entry's head after a jump does not chain.
- FSM states: IDLE, ROLL, STEP, JUMP, COMMIT, DONE.
  - IDLE: if `roll_req` is high, go to ROLL; otherwise stay.
  - ROLL: latch the die into `last_roll`. If it is a 6, increment the six counter. Go to STEP.
  - STEP: tentative = pos + roll.
    - If tentative > BOARD_SIZE, tentative = pos (no move).
    - If this is the third consecutive six, tentative = pos (move forfeited).
  - JUMP: apply the table lookup to tentative.
  - COMMIT: write the new position and pulse `move_valid`.
    - If the new position == BOARD_SIZE (directly or by ladder): set `game_over`, set `winner` = `cur_player`, go to DONE.
    - Else if roll == 6 and the six counter < 3: same player goes again.
    - Else: `cur_player` = (`cur_player` + 1) mod NUM_PLAYERS and the six counter clears.
    - Either non-winning case returns to IDLE.
  - DONE: ignore `roll_req`; hold all outputs. Only reset exits.
- An overshooting 6 still grants the extra turn. The third consecutive 6 passes the turn and clears the counter.

## Timing
- Edge E0 samples `roll_req` in IDLE. `busy` is high in the cycles after E0 through E4.
- `last_roll` updates at E1.
- `positions`, `cur_player`, `game_over` and `winner` update at E4. `move_valid` is high for exactly the cycle after E4.
- Turn latency is 5 cycles. The next `roll_req` can be sampled at E5.
- `roll_req` while busy or in DONE is dropped, not queued. Holding `roll_req` high gives back-to-back turns every 5 cycles.
- Reset asserted mid-turn aborts the turn: all outputs return to reset values at that edge, and no `move_valid` is produced.

## Test plan
- Reset, then force rolls of 3,4,5 with NUM_PLAYERS = 4 and an empty table -> positions 3,4,5,0; `cur_player` goes 1,2,3; `move_valid` pulses 5 cycles apart.
- Load entry 0 = (3→22) and entry 1 = (17→4). Player 0 forced 3 -> position 22. Player 1 forced 6 then 6 then 5 (three rolls of the same player, extra turns) -> 6, 12, 17→4 with no chain.
- Player at 98 forced roll 5 -> stays 98; `move_valid` pulses; turn passes. Forced roll 2 -> 100; `game_over` = 1; `winner` = that player; later `roll_req` is ignored.
- Force three consecutive 6s for player 0 from 0 -> positions 6, 12, then 12 (forfeit); `cur_player` becomes 1.
- Assert `reset` in the cycle after E2 -> next cycle shows all outputs at reset values and no `move_valid` pulse. Attempt a `jump_wr_en` while `busy` -> the table is unchanged.
- `dice_force_en` = 0 for 1000 turns -> every `last_roll` is in 1..6 and each face appears more than 100 times.
